// File: rtl/video_capture_pkg.sv
// Shared types and constants for the video capture block: FSM states,
// CRC-16-CCITT constants and default capture geometry.
package video_capture_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_VSKIP,
      ST_HWAIT,
      ST_HSKIP,
      ST_ACTIVE
   } cap_state_t;

   localparam logic [15:0] CRC_POLY = 16'h1021;
   localparam logic [15:0] CRC_INIT = 16'hFFFF;

   localparam int DEF_H_ACTIVE = 512;
   localparam int DEF_V_ACTIVE = 342;
   localparam int DEF_H_SKIP   = 64;
   localparam int DEF_V_SKIP   = 28;

   localparam int FIFO_DEPTH = 16;
   localparam int FIFO_W     = 10;

endpackage

// File: rtl/video_capture_fifo.sv
// First-word-fall-through FIFO; a push into a full FIFO is taken only when
// a pop happens in the same cycle.
module video_capture_fifo #(
   parameter int WIDTH = 10,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             pop,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // storage carries only data, so it is left out of reset
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/video_capture.sv
// Captures 1-bit-per-pixel video into a tagged byte stream through a FIFO.
// Define VIDEO_CAPTURE_CRC_EN to add a per-frame CRC-16-CCITT.
module video_capture
   import video_capture_pkg::*;
#(
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int H_SKIP   = DEF_H_SKIP,
   parameter int V_SKIP   = DEF_V_SKIP
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        pix_ce,
   input  logic        hs_n,
   input  logic        vs_n,
   input  logic        pix,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [7:0]  out_data,
   output logic        out_sof,
   output logic        out_eol,
   output logic        overflow,
   output logic        short_frame,
   output logic [15:0] frame_cnt,
   output logic [15:0] frame_crc,
   output logic        crc_valid
);

   cap_state_t        state, state_nxt;
   logic              hs_n_p0, hs_n_p1, vs_n_p0, vs_n_p1;
   logic              hs_fall, vs_fall;
   logic [15:0]       pix_cnt, line_cnt;
   logic [6:0]        shift_p0;
   logic [7:0]        byte_p0;
   logic              sof_p0, eol_p0, vld_p0;
   logic              cnt_clr, cnt_inc, line_clr, line_inc;
   logic              sample, frame_done, abort;
   logic              fifo_full, fifo_empty, pop;
   logic [FIFO_W-1:0] fifo_rd;

   assign hs_fall = hs_n_p1 && !hs_n_p0;
   assign vs_fall = vs_n_p1 && !vs_n_p0;

   always_comb begin
      state_nxt  = state;
      cnt_clr    = 1'b0;
      cnt_inc    = 1'b0;
      line_clr   = 1'b0;
      line_inc   = 1'b0;
      sample     = 1'b0;
      frame_done = 1'b0;
      abort      = 1'b0;
      case (state)
         ST_IDLE: if (vs_fall) begin
            state_nxt = (V_SKIP == 0) ? ST_HWAIT : ST_VSKIP;
            cnt_clr   = 1'b1;
            line_clr  = 1'b1;
         end
         ST_VSKIP: if (hs_fall) begin
            if (pix_cnt == 16'(V_SKIP - 1)) begin
               state_nxt = ST_HWAIT;
               cnt_clr   = 1'b1;
            end else begin
               cnt_inc = 1'b1;
            end
         end
         ST_HWAIT: if (hs_fall) begin
            state_nxt = (H_SKIP == 0) ? ST_ACTIVE : ST_HSKIP;
            cnt_clr   = 1'b1;
         end
         ST_HSKIP: if (pix_ce) begin
            if (pix_cnt == 16'(H_SKIP - 1)) begin
               state_nxt = ST_ACTIVE;
               cnt_clr   = 1'b1;
            end else begin
               cnt_inc = 1'b1;
            end
         end
         ST_ACTIVE: if (pix_ce) begin
            sample = 1'b1;
            if (pix_cnt == 16'(H_ACTIVE - 1)) begin
               cnt_clr = 1'b1;
               if (line_cnt == 16'(V_ACTIVE - 1)) begin
                  state_nxt  = ST_IDLE;
                  frame_done = 1'b1;
               end else begin
                  state_nxt = ST_HWAIT;
                  line_inc  = 1'b1;
               end
            end else begin
               cnt_inc = 1'b1;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
      // a new vsync always wins; only a frame already past vblank counts as short
      if (vs_fall && state != ST_IDLE) begin
         state_nxt  = (V_SKIP == 0) ? ST_HWAIT : ST_VSKIP;
         cnt_clr    = 1'b1;
         cnt_inc    = 1'b0;
         line_clr   = 1'b1;
         line_inc   = 1'b0;
         sample     = 1'b0;
         frame_done = 1'b0;
         abort      = (state != ST_VSKIP);
      end
   end

   // stage p0: byte assembly; the pixel count doubles as bit index within the byte
   assign byte_p0 = {shift_p0, pix};
   assign vld_p0  = sample && (pix_cnt[2:0] == 3'd7);
   assign sof_p0  = (line_cnt == '0) && (pix_cnt[15:3] == '0);
   assign eol_p0  = (pix_cnt == 16'(H_ACTIVE - 1));
   assign pop     = out_valid && out_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_IDLE;
         hs_n_p0     <= 1'b1;
         hs_n_p1     <= 1'b1;
         vs_n_p0     <= 1'b1;
         vs_n_p1     <= 1'b1;
         pix_cnt     <= '0;
         line_cnt    <= '0;
         shift_p0    <= '0;
         overflow    <= 1'b0;
         short_frame <= 1'b0;
         frame_cnt   <= '0;
      end else begin
         state   <= state_nxt;
         hs_n_p0 <= hs_n;
         hs_n_p1 <= hs_n_p0;
         vs_n_p0 <= vs_n;
         vs_n_p1 <= vs_n_p0;
         if (cnt_clr)       pix_cnt <= '0;
         else if (cnt_inc)  pix_cnt <= pix_cnt + 16'd1;
         if (line_clr)      line_cnt <= '0;
         else if (line_inc) line_cnt <= line_cnt + 16'd1;
         if (abort)         shift_p0 <= '0;
         else if (sample)   shift_p0 <= byte_p0[6:0];
         if (vld_p0 && fifo_full && !pop) overflow <= 1'b1;
         if (abort)         short_frame <= 1'b1;
         if (frame_done)    frame_cnt <= frame_cnt + 16'd1;
      end
   end

   video_capture_fifo #(
      .WIDTH (FIFO_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push    (vld_p0),
      .wr_data ({byte_p0, sof_p0, eol_p0}),
      .pop     (pop),
      .rd_data (fifo_rd),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   assign out_valid = !fifo_empty;
   assign out_data  = fifo_rd[9:2];
   assign out_sof   = fifo_rd[1];
   assign out_eol   = fifo_rd[0];

`ifdef VIDEO_CAPTURE_CRC_EN
   logic [15:0] crc_acc, crc_nxt;

   function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] d);
      logic [15:0] c;
      c = crc;
      for (int i = 7; i >= 0; i--) begin
         if (c[15] ^ d[i]) c = {c[14:0], 1'b0} ^ CRC_POLY;
         else              c = {c[14:0], 1'b0};
      end
      return c;
   endfunction

   // every generated byte feeds the CRC, including ones the full FIFO drops
   assign crc_nxt = vld_p0 ? crc16_byte(crc_acc, byte_p0) : crc_acc;

   always_ff @(posedge clk) begin
      if (reset) begin
         crc_acc   <= CRC_INIT;
         frame_crc <= '0;
         crc_valid <= 1'b0;
      end else begin
         crc_valid <= frame_done;
         crc_acc   <= vs_fall ? CRC_INIT : crc_nxt;
         if (frame_done) frame_crc <= crc_nxt;
      end
   end
`else
   assign frame_crc = '0;
   assign crc_valid = 1'b0;
`endif

endmodule

// File: tb/tb_video_capture.sv
// Bench for video_capture: three geometries, frame driver with a byte scoreboard.
module tb_video_capture;

`ifdef VIDEO_CAPTURE_CRC_EN
   localparam bit CRC_ON = 1'b1;
`else
   localparam bit CRC_ON = 1'b0;
`endif

   logic        clk;
   logic        reset;
   logic        hs_v [3];
   logic        vs_v [3];
   logic        ce_v [3];
   logic        pix_v [3];
   logic        rdy_v [3];
   logic        valid_v [3];
   logic        sof_v [3];
   logic        eol_v [3];
   logic        ovf_v [3];
   logic        short_v [3];
   logic        crcv_v [3];
   logic [7:0]  data_v [3];
   logic [15:0] fcnt_v [3];
   logic [15:0] crc_v [3];

   int          sel;
   int          rdy_mode;
   int          vec_cnt;
   int          err_cnt;
   int          crcv_seen;
   int          efc;
   logic [15:0] exp_crc;
   logic [9:0]  exp_q [$];

   typedef struct {
      logic [31:0] pat;
      int          gap;
      int          rmode;
   } vec_t;
   vec_t tbl [4];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   video_capture #(.H_ACTIVE(16), .V_ACTIVE(2), .H_SKIP(3), .V_SKIP(2)) dut_a (
      .clk(clk), .reset(reset), .pix_ce(ce_v[0]), .hs_n(hs_v[0]), .vs_n(vs_v[0]), .pix(pix_v[0]),
      .out_valid(valid_v[0]), .out_ready(rdy_v[0]), .out_data(data_v[0]), .out_sof(sof_v[0]),
      .out_eol(eol_v[0]), .overflow(ovf_v[0]), .short_frame(short_v[0]), .frame_cnt(fcnt_v[0]),
      .frame_crc(crc_v[0]), .crc_valid(crcv_v[0]));

   video_capture #(.H_ACTIVE(64), .V_ACTIVE(4), .H_SKIP(3), .V_SKIP(2)) dut_b (
      .clk(clk), .reset(reset), .pix_ce(ce_v[1]), .hs_n(hs_v[1]), .vs_n(vs_v[1]), .pix(pix_v[1]),
      .out_valid(valid_v[1]), .out_ready(rdy_v[1]), .out_data(data_v[1]), .out_sof(sof_v[1]),
      .out_eol(eol_v[1]), .overflow(ovf_v[1]), .short_frame(short_v[1]), .frame_cnt(fcnt_v[1]),
      .frame_crc(crc_v[1]), .crc_valid(crcv_v[1]));

   video_capture #(.H_ACTIVE(8), .V_ACTIVE(1), .H_SKIP(3), .V_SKIP(2)) dut_c (
      .clk(clk), .reset(reset), .pix_ce(ce_v[2]), .hs_n(hs_v[2]), .vs_n(vs_v[2]), .pix(pix_v[2]),
      .out_valid(valid_v[2]), .out_ready(rdy_v[2]), .out_data(data_v[2]), .out_sof(sof_v[2]),
      .out_eol(eol_v[2]), .overflow(ovf_v[2]), .short_frame(short_v[2]), .frame_cnt(fcnt_v[2]),
      .frame_crc(crc_v[2]), .crc_valid(crcv_v[2]));

   function automatic logic [15:0] crc_upd(input logic [15:0] c_in, input logic [7:0] d);
      logic [15:0] c;
      c = c_in ^ {d, 8'h00};
      for (int i = 0; i < 8; i++) c = c[15] ? ({c[14:0], 1'b0} ^ 16'h1021) : {c[14:0], 1'b0};
      return c;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // one clock: drive inputs at negedge, score any byte that pops on the coming edge
   task automatic cyc(input logic h, input logic v, input logic c, input logic p);
      logic [9:0] e;
      hs_v[sel]  = h;
      vs_v[sel]  = v;
      ce_v[sel]  = c;
      pix_v[sel] = p;
      rdy_v[sel] = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
      if (valid_v[sel] && rdy_v[sel]) begin
         if (exp_q.size() == 0) begin
            check("extra_byte", 32'({data_v[sel], sof_v[sel], eol_v[sel]}), 32'h400);
         end else begin
            e = exp_q.pop_front();
            check("byte", 32'({data_v[sel], sof_v[sel], eol_v[sel]}), 32'(e));
         end
      end
      @(posedge clk);
      @(negedge clk);
      if (crcv_v[sel]) crcv_seen++;
   endtask

   task automatic frame(input int ha, input int va, input int pmode, input logic [31:0] pat,
                        input int gap, input int keep_max, input int ab_line, input int ab_pix,
                        input int rs_line, input int rs_pix);
      logic [7:0] sh;
      logic       p;
      int         nb;
      sh      = '0;
      nb      = 0;
      exp_crc = 16'hFFFF;
      cyc(1, 0, 0, 0); cyc(1, 0, 0, 0); cyc(1, 1, 0, 0); cyc(1, 1, 0, 0);
      for (int b = 0; b < 2; b++) begin
         cyc(0, 1, 0, 0); cyc(0, 1, 0, 0);
         repeat (4) cyc(1, 1, 0, 0);
      end
      for (int ln = 0; ln < va; ln++) begin
         cyc(0, 1, 0, 0); cyc(0, 1, 0, 0);
         repeat (3) cyc(1, 1, 1, 0);
         for (int x = 0; x < ha; x++) begin
            if (ln == ab_line && x == ab_pix) begin
               cyc(1, 0, 0, 0); cyc(1, 0, 0, 0); cyc(1, 1, 0, 0);
               return;
            end
            if (ln == rs_line && x == rs_pix) begin
               reset = 1'b1;
               cyc(1, 1, 0, 0);
               reset = 1'b0;
               exp_q.delete();
               return;
            end
            if (gap != 0) cyc(1, 1, 0, 0);
            case (pmode)
               0:       p = pat[31 - (ln * ha + x)];
               1:       p = 1'b1;
               default: p = 1'($urandom_range(0, 1));
            endcase
            cyc(1, 1, 1, p);
            sh = {sh[6:0], p};
            if (x % 8 == 7) begin
               exp_crc = crc_upd(exp_crc, sh);
               if (nb < keep_max) exp_q.push_back({sh, 1'(ln == 0 && x == 7), 1'(x == ha - 1)});
               nb++;
            end
         end
         repeat (3) cyc(1, 1, 0, 0);
      end
      repeat (2) cyc(1, 1, 0, 0);
   endtask

   task automatic drain();
      for (int i = 0; i < 200 && exp_q.size() != 0; i++) cyc(1, 1, 0, 0);
      repeat (4) cyc(1, 1, 0, 0);
      check("bytes_missing", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0] = '{32'hAAAA_AAAA, 0, 0};
      tbl[1] = '{32'hF00F_3C5A, 1, 1};
      tbl[2] = '{32'h0123_FEDC, 0, 1};
      tbl[3] = '{32'hFFFF_0000, 1, 0};

      vec_cnt   = 0;
      err_cnt   = 0;
      crcv_seen = 0;
      sel       = 0;
      rdy_mode  = 0;
      efc       = 0;
      for (int s = 0; s < 3; s++) begin
         hs_v[s] = 1'b1; vs_v[s] = 1'b1; ce_v[s] = 1'b0; pix_v[s] = 1'b0; rdy_v[s] = 1'b1;
      end
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;

      for (int s = 0; s < 3; s++) begin
         check("rst_valid", 32'(valid_v[s]), 32'd0);
         check("rst_overflow", 32'(ovf_v[s]), 32'd0);
         check("rst_short", 32'(short_v[s]), 32'd0);
         check("rst_frame_cnt", 32'(fcnt_v[s]), 32'd0);
         check("rst_crc", 32'(crc_v[s]), 32'd0);
         check("rst_crc_valid", 32'(crcv_v[s]), 32'd0);
      end

      // table-driven frames on the 16x2 instance
      sel = 0;
      for (int v = 0; v < 4; v++) begin
         rdy_mode  = tbl[v].rmode;
         crcv_seen = 0;
         frame(16, 2, 0, tbl[v].pat, tbl[v].gap, 16, -1, -1, -1, -1);
         drain();
         efc++;
         check("frame_cnt", 32'(fcnt_v[0]), 32'(efc));
         check("overflow", 32'(ovf_v[0]), 32'd0);
         check("short_frame", 32'(short_v[0]), 32'd0);
         check("frame_crc", 32'(crc_v[0]), CRC_ON ? 32'(exp_crc) : 32'd0);
         check("crc_pulses", 32'(crcv_seen), CRC_ON ? 32'd1 : 32'd0);
      end

      // early vsync at line 1 pixel 5, then a full frame
      rdy_mode  = 0;
      crcv_seen = 0;
      frame(16, 2, 0, 32'hAAAA_AAAA, 0, 16, 1, 5, -1, -1);
      drain();
      check("early_short", 32'(short_v[0]), 32'd1);
      check("early_frame_cnt", 32'(fcnt_v[0]), 32'(efc));
      check("early_crc_pulses", 32'(crcv_seen), 32'd0);
      frame(16, 2, 0, 32'h5A5A_C3C3, 0, 16, -1, -1, -1, -1);
      drain();
      efc++;
      check("after_early_frame_cnt", 32'(fcnt_v[0]), 32'(efc));
      check("after_early_short", 32'(short_v[0]), 32'd1);

      // backpressure on the 64x4 instance: 32 bytes generated, 16 held
      sel       = 1;
      rdy_mode  = 2;
      crcv_seen = 0;
      frame(64, 4, 2, 32'h0, 0, 16, -1, -1, -1, -1);
      check("bp_overflow", 32'(ovf_v[1]), 32'd1);
      check("bp_frame_cnt", 32'(fcnt_v[1]), 32'd1);
      check("bp_valid", 32'(valid_v[1]), 32'd1);
      check("bp_frame_crc", 32'(crc_v[1]), CRC_ON ? 32'(exp_crc) : 32'd0);
      check("bp_crc_pulses", 32'(crcv_seen), CRC_ON ? 32'd1 : 32'd0);
      rdy_mode = 0;
      drain();
      check("bp_empty", 32'(valid_v[1]), 32'd0);

      // single 0xFF byte on the 8x1 instance
      sel       = 2;
      rdy_mode  = 0;
      crcv_seen = 0;
      frame(8, 1, 1, 32'h0, 0, 16, -1, -1, -1, -1);
      drain();
      check("ff_frame_crc", 32'(crc_v[2]), CRC_ON ? 32'hFF00 : 32'd0);
      check("ff_crc_pulses", 32'(crcv_seen), CRC_ON ? 32'd1 : 32'd0);
      check("ff_frame_cnt", 32'(fcnt_v[2]), 32'd1);

      // reset mid-line with line 0 bytes still queued
      sel      = 0;
      rdy_mode = 2;
      frame(16, 2, 0, 32'hC3C3_A5A5, 0, 16, -1, -1, 1, 3);
      check("mid_rst_valid", 32'(valid_v[0]), 32'd0);
      check("mid_rst_frame_cnt", 32'(fcnt_v[0]), 32'd0);
      check("mid_rst_short", 32'(short_v[0]), 32'd0);
      rdy_mode = 0;
      for (int l = 0; l < 3; l++) begin
         cyc(0, 1, 0, 0); cyc(0, 1, 0, 0);
         repeat (24) cyc(1, 1, 1, 1);
      end
      check("idle_no_capture", 32'(valid_v[0]), 32'd0);
      frame(16, 2, 0, 32'hAAAA_AAAA, 0, 16, -1, -1, -1, -1);
      drain();
      check("resume_frame_cnt", 32'(fcnt_v[0]), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
